// File: rtl/uart_prog_loader.sv
// Serial program loader: 8N1 UART frames (A5, LEN, data, CSUM) written into program RAM; CPU held in reset while loading.
// Latency: we/w_addr/w_data one cycle after the byte's rx_valid; done/cpu_rst_n release one cycle after the checksum byte.
// Backpressure: none; the RAM write port always accepts, and bytes are consumed at line rate including back-to-back frames.
module uart_prog_loader #(
  parameter int CLK_HZ         = 27_000_000,
  parameter int BAUD           = 115200,
  parameter int TIMEOUT_CYCLES = 2_700_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       we,
  output logic [7:0] w_addr,
  output logic [7:0] w_data,
  output logic       cpu_rst_n,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int GAP_W        = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CYCLES);
  localparam logic [7:0]       SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} u_state_t;
  typedef enum logic [1:0] {L_IDLE, L_LEN, L_DATA, L_CSUM} l_state_t;

  // ---------------- UART receiver ----------------
  logic             rx_meta, rx_sync, rx_prev;
  u_state_t         u_state, u_nxt;
  logic [CNT_W-1:0] bit_cnt, cnt_nxt;
  logic [2:0]       bit_idx, idx_nxt;
  logic [7:0]       shreg, sh_nxt;
  logic [7:0]       rx_byte, byte_nxt;
  logic             rx_valid, valid_nxt;
  logic             rx_ferr, ferr_nxt;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection; idles high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      u_state  <= U_IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      u_state  <= u_nxt;
      bit_cnt  <= cnt_nxt;
      bit_idx  <= idx_nxt;
      shreg    <= sh_nxt;
      rx_byte  <= byte_nxt;
      rx_valid <= valid_nxt;
      rx_ferr  <= ferr_nxt;
    end
  end

  // Receiver next state: start-bit recheck at half bit, then one sample per bit period at bit centres.
  always_comb begin
    u_nxt     = u_state;
    cnt_nxt   = bit_cnt;
    idx_nxt   = bit_idx;
    sh_nxt    = shreg;
    byte_nxt  = rx_byte;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
    case (u_state)
      U_IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (rx_prev && !rx_sync) u_nxt = U_START;
      end
      U_START: begin
        if (bit_cnt == HALF_LAST) begin
          cnt_nxt = '0;
          // A line already back high at mid start bit was only a glitch.
          u_nxt   = rx_sync ? U_IDLE : U_DATA;
        end else begin
          cnt_nxt = bit_cnt + 1'b1;
        end
      end
      U_DATA: begin
        if (bit_cnt == BIT_LAST) begin
          cnt_nxt = '0;
          sh_nxt  = {rx_sync, shreg[7:1]};
          idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) u_nxt = U_STOP;
        end else begin
          cnt_nxt = bit_cnt + 1'b1;
        end
      end
      U_STOP: begin
        if (bit_cnt == BIT_LAST) begin
          cnt_nxt = '0;
          if (rx_sync) begin
            valid_nxt = 1'b1;
            byte_nxt  = shreg;
          end else begin
            ferr_nxt = 1'b1;
          end
          // Returning to idle at mid stop bit leaves half a bit to catch a back-to-back start edge.
          u_nxt = U_IDLE;
        end else begin
          cnt_nxt = bit_cnt + 1'b1;
        end
      end
      default: u_nxt = U_IDLE;
    endcase
  end

  // ---------------- Frame loader ----------------
  l_state_t         l_state, l_nxt;
  logic [8:0]       remain, remain_nxt;
  logic [7:0]       addr, addr_nxt;
  logic [7:0]       sum, sum_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic             we_nxt, busy_nxt, done_nxt, err_nxt, cpu_rst_n_nxt;
  logic [7:0]       w_addr_nxt, w_data_nxt;

  // Loader state, counters and registered outputs; reset releases the CPU to run existing RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      l_state   <= L_IDLE;
      remain    <= '0;
      addr      <= '0;
      sum       <= '0;
      gap_cnt   <= '0;
      we        <= 1'b0;
      w_addr    <= '0;
      w_data    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cpu_rst_n <= 1'b1;
    end else begin
      l_state   <= l_nxt;
      remain    <= remain_nxt;
      addr      <= addr_nxt;
      sum       <= sum_nxt;
      gap_cnt   <= gap_nxt;
      we        <= we_nxt;
      w_addr    <= w_addr_nxt;
      w_data    <= w_data_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      cpu_rst_n <= cpu_rst_n_nxt;
    end
  end

  // Loader next state: sync/length/data/checksum sequencing with framing-error and gap-timeout aborts.
  always_comb begin
    l_nxt         = l_state;
    remain_nxt    = remain;
    addr_nxt      = addr;
    sum_nxt       = sum;
    gap_nxt       = gap_cnt;
    we_nxt        = 1'b0;
    w_addr_nxt    = w_addr;
    w_data_nxt    = w_data;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    err_nxt       = err;
    cpu_rst_n_nxt = cpu_rst_n;
    if (l_state == L_IDLE) begin
      gap_nxt = '0;
      if (rx_valid && rx_byte == SYNC_BYTE) begin
        l_nxt         = L_LEN;
        busy_nxt      = 1'b1;
        cpu_rst_n_nxt = 1'b0;
        err_nxt       = 1'b0;
      end
    end else if (rx_ferr || gap_cnt == GAP_LIMIT) begin
      // Abandon the frame; the CPU stays in reset until a later frame succeeds.
      l_nxt    = L_IDLE;
      err_nxt  = 1'b1;
      busy_nxt = 1'b0;
      gap_nxt  = '0;
    end else if (rx_valid) begin
      gap_nxt = '0;
      case (l_state)
        L_LEN: begin
          remain_nxt = (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};
          addr_nxt   = '0;
          sum_nxt    = '0;
          l_nxt      = L_DATA;
        end
        L_DATA: begin
          we_nxt     = 1'b1;
          w_addr_nxt = addr;
          w_data_nxt = rx_byte;
          addr_nxt   = addr + 8'd1;
          sum_nxt    = sum + rx_byte;
          remain_nxt = remain - 9'd1;
          if (remain == 9'd1) l_nxt = L_CSUM;
        end
        L_CSUM: begin
          busy_nxt = 1'b0;
          l_nxt    = L_IDLE;
          if (rx_byte == sum) begin
            done_nxt      = 1'b1;
            cpu_rst_n_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
        default: l_nxt = L_IDLE;
      endcase
    end else begin
      gap_nxt = gap_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: frame-level reference model predicts writes and outcomes; a per-cycle compare process checks them.
// Latency: expectations are queued before each frame and consumed as the DUT writes.
// Backpressure: none; the serial driver runs at line rate with optional idle bits.
module tb_uart_prog_loader;

  localparam int CPB = 10;
  localparam int TMO = 600;
  localparam logic [20:0] RESET_VEC = {1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       we;
  logic [7:0] w_addr, w_data;
  logic       cpu_rst_n, busy, done, err;

  uart_prog_loader #(.CLK_HZ(1_000_000), .BAUD(100_000), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .rx(rx), .we(we), .w_addr(w_addr), .w_data(w_data),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] wlog[$];
  int          exp_done = 0;
  int          done_seen = 0;
  logic [7:0]  fr[$];
  bit          exp_ok;
  logic [15:0] cmp_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [20:0] out_vec();
    return {we, w_addr, w_data, busy, done, err, cpu_rst_n};
  endfunction

  // Every write and done pulse must match the next model expectation.
  always @(negedge clk) begin
    if (rst) begin
      if (we) begin
        wlog.push_back({w_addr, w_data});
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_we actual addr=0x%0h data=0x%0h required no write", w_addr, w_data);
        end else begin
          cmp_e = exp_q.pop_front();
          chk("write_addr_data", {16'h0, w_addr, w_data}, {16'h0, cmp_e});
          chk("we_in_frame", {30'h0, busy, cpu_rst_n}, 32'h2);
        end
      end
      if (done) begin
        done_seen++;
        checks++;
        if (exp_done == 0) begin
          failures++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          exp_done--;
        end
      end
    end
  end

  // Serial driver; every call starts and ends aligned to a negedge.
  task automatic send_byte(input logic [7:0] b, input bit stop_hi, input int gap_bits);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_hi;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (gap_bits * CPB) @(negedge clk);
  endtask

  // Model the frame in fr from its contents, then send n_send bytes (byte fe_idx with a low stop bit).
  task automatic run_frame(input int n_send, input int fe_idx, input int max_gap);
    int         len, deliv, gap;
    logic [7:0] s;
    bit         finished;
    len   = (fr[1] == 8'd0) ? 256 : int'(fr[1]);
    deliv = (fe_idx >= 0 && fe_idx < n_send) ? fe_idx : n_send;
    s     = 8'd0;
    for (int k = 0; k < len; k++) begin
      if (2 + k < fr.size()) s = s + fr[2 + k];
      if (deliv >= 2 && 2 + k < deliv) exp_q.push_back({8'(k), fr[2 + k]});
    end
    finished = (fe_idx < 0) && (deliv > 2 + len);
    exp_ok   = finished && (fr[2 + len] == s);
    if (exp_ok) exp_done++;
    for (int i = 0; i < n_send; i++) begin
      gap = (i == n_send - 1) ? 0 : int'($urandom_range(0, max_gap));
      send_byte(fr[i], i != fe_idx, gap);
      if (i == fe_idx) break;
      if (i == 1) chk("in_frame_busy_cpu_err", {29'h0, busy, cpu_rst_n, err}, 32'h4);
    end
  endtask

  task automatic check_outcome(input int done_before, input bit ok);
    chk("end_busy", {31'h0, busy}, 32'h0);
    chk("end_err", {31'h0, err}, {31'h0, ~ok});
    chk("end_cpu_rst_n", {31'h0, cpu_rst_n}, {31'h0, ok});
    chk("end_done_count", done_seen - done_before, {31'h0, ok});
    chk("end_writes_left", exp_q.size(), 32'h0);
    exp_q.delete();
    exp_done = 0;
  endtask

  task automatic make_frame(input int len, input bit bad);
    logic [7:0] b, s;
    fr.delete();
    fr.push_back(8'hA5);
    fr.push_back(8'(len));
    s = 8'd0;
    for (int k = 0; k < ((len == 0) ? 256 : len); k++) begin
      b = 8'($urandom_range(0, 255));
      fr.push_back(b);
      s = s + b;
    end
    fr.push_back(bad ? s + 8'd1 : s);
  endtask

  initial begin
    int          db, wb;
    bit          ok_l;
    logic [20:0] snap;
    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {11'h0, out_vec()}, {11'h0, RESET_VEC});
    rst = 1'b1;

    // Idle line: outputs must not move.
    snap = out_vec();
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (snap === RESET_VEC) snap = out_vec();
    end
    chk("idle_outputs", {11'h0, snap}, {11'h0, RESET_VEC});

    // Valid three-byte frame.
    fr = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    wlog.delete();
    db = done_seen;
    run_frame(fr.size(), -1, 2);
    repeat (3 * CPB) @(negedge clk);
    ok_l = exp_ok;
    chk("a_model_ok", {31'h0, ok_l}, 32'h1);
    check_outcome(db, ok_l);
    chk("a_wcount", wlog.size(), 32'd3);
    chk("a_w0", {16'h0, wlog[0]}, 32'h0011);
    chk("a_w1", {16'h0, wlog[1]}, 32'h0122);
    chk("a_w2", {16'h0, wlog[2]}, 32'h0233);

    // Bad checksum.
    fr = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h04};
    db = done_seen;
    wb = wlog.size();
    run_frame(fr.size(), -1, 2);
    repeat (3 * CPB) @(negedge clk);
    check_outcome(db, exp_ok);
    chk("b_err", {31'h0, err}, 32'h1);
    chk("b_cpu_rst_n", {31'h0, cpu_rst_n}, 32'h0);
    chk("b_wcount", wlog.size() - wb, 32'd2);

    // Following valid frame clears err and releases the CPU.
    make_frame(4, 1'b0);
    db = done_seen;
    run_frame(fr.size(), -1, 2);
    repeat (3 * CPB) @(negedge clk);
    check_outcome(db, exp_ok);
    chk("c_err_cleared", {31'h0, err}, 32'h0);

    // Noise in idle: two bytes and a short glitch.
    db = done_seen;
    wb = wlog.size();
    send_byte(8'h00, 1'b1, 1);
    send_byte(8'hFF, 1'b1, 1);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    chk("noise_busy", {31'h0, busy}, 32'h0);
    chk("noise_cpu_rst_n", {31'h0, cpu_rst_n}, 32'h1);
    chk("noise_done", done_seen - db, 32'h0);
    chk("noise_writes", wlog.size() - wb, 32'h0);

    // Framing error on the first data byte.
    fr = '{8'hA5, 8'h02, 8'h3C, 8'h4D, 8'h89};
    db = done_seen;
    wb = wlog.size();
    run_frame(fr.size(), 2, 2);
    repeat (3 * CPB) @(negedge clk);
    check_outcome(db, exp_ok);
    chk("fe_writes", wlog.size() - wb, 32'h0);

    // Gap timeout after one data byte.
    fr = '{8'hA5, 8'h02, 8'h7E, 8'h11, 8'h8F};
    db = done_seen;
    wb = wlog.size();
    run_frame(3, -1, 2);
    repeat (TMO / 2) @(negedge clk);
    chk("tmo_busy_before", {31'h0, busy}, 32'h1);
    repeat (TMO / 2 + 5 * CPB) @(negedge clk);
    check_outcome(db, exp_ok);
    chk("tmo_writes", wlog.size() - wb, 32'h1);

    // LEN=0 frame of 256 bytes, back-to-back, includes an embedded A5 data byte.
    fr.delete();
    fr.push_back(8'hA5);
    fr.push_back(8'h00);
    for (int i = 0; i < 256; i++) fr.push_back(8'(i));
    fr.push_back(8'h80);
    db = done_seen;
    wb = wlog.size();
    run_frame(fr.size(), -1, 0);
    repeat (3 * CPB) @(negedge clk);
    ok_l = exp_ok;
    chk("l0_model_ok", {31'h0, ok_l}, 32'h1);
    check_outcome(db, ok_l);
    chk("l0_wcount", wlog.size() - wb, 32'd256);
    chk("l0_first", {16'h0, wlog[wb]}, 32'h0000);
    chk("l0_a5", {16'h0, wlog[wb + 165]}, 32'hA5A5);
    chk("l0_last", {16'h0, wlog[wb + 255]}, 32'hFFFF);

    // Reset after two of three data bytes, then a full reload.
    fr = '{8'hA5, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h31};
    run_frame(4, -1, 1);
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_async_outputs", {11'h0, out_vec()}, {11'h0, RESET_VEC});
    chk("rst_writes_done", exp_q.size(), 32'h0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    db = done_seen;
    run_frame(fr.size(), -1, 2);
    repeat (3 * CPB) @(negedge clk);
    ok_l = exp_ok;
    chk("r_model_ok", {31'h0, ok_l}, 32'h1);
    check_outcome(db, ok_l);

    // Randomized frames, some with corrupted checksums.
    for (int r = 0; r < 10; r++) begin
      make_frame(int'($urandom_range(1, 8)), ($urandom_range(0, 3) == 0));
      db = done_seen;
      run_frame(fr.size(), -1, 2);
      repeat (3 * CPB) @(negedge clk);
      check_outcome(db, exp_ok);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
